shift_reg_univ: RTL and testbench

Parametrised universal shift register: the successor to the team's single-bit D flip-flop, generalised to WIDTH bits. It adds an enable, eight operating modes (hold, shift, rotate, load, clear), a registered serial output, and a frame counter that pulses once every WIDTH shift/rotate operations. It sits in serial links and bit-stream paths: serialising parallel words, deserialising serial streams, and delay/rotate stages.

---
 rtl/shift_reg_univ.sv | 134 +++++++++++++
 tb/tb_shift_reg_univ.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register.
// Holds, shifts, rotates, loads or clears a WIDTH-bit word. It also keeps a
// registered serial output and a frame counter that pulses o_frame_done once
// every WIDTH shift/rotate operations. All outputs come straight from flops.
//
// Handshake: there is no valid/ready pair. i_en acts as a per-cycle
// qualifier, and i_mode, i_serial_in and i_data are consumed only on a rising
// edge where i_en=1. Nothing backpressures, and every qualified edge executes
// exactly one operation.
module shift_reg_univ #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}},
  localparam int unsigned           CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_serial_in,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_serial_out,
  output logic [CW-1:0]    o_count,
  output logic             o_frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  // Count value on which the next shift op closes the frame.
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_data;
  logic             r_serial_out;
  logic [CW-1:0]    r_count;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_next_data;
  logic             w_next_serial;
  logic             w_shift_op;
  logic             w_count_clr;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  // Work out the next data word and serial bit, and classify the operation.
  always_comb begin
    w_next_data   = r_data;
    w_next_serial = r_serial_out;
    w_shift_op    = 1'b0;
    w_count_clr   = 1'b0;
    if (i_en) begin
      case (w_mode)
        MODE_SHL: begin
          w_next_data   = {r_data[WIDTH-2:0], i_serial_in};
          w_next_serial = r_data[WIDTH-1];
          w_shift_op    = 1'b1;
        end
        MODE_SHR: begin
          w_next_data   = {i_serial_in, r_data[WIDTH-1:1]};
          w_next_serial = r_data[0];
          w_shift_op    = 1'b1;
        end
        MODE_ROL: begin
          w_next_data   = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
          w_next_serial = r_data[WIDTH-1];
          w_shift_op    = 1'b1;
        end
        MODE_ROR: begin
          w_next_data   = {r_data[0], r_data[WIDTH-1:1]};
          w_next_serial = r_data[0];
          w_shift_op    = 1'b1;
        end
        MODE_LOAD: begin
          w_next_data   = i_data;
          w_next_serial = 1'b0;
          w_count_clr   = 1'b1;
        end
        MODE_CLEAR: begin
          w_next_data   = RESET_VAL;
          w_next_serial = 1'b0;
          w_count_clr   = 1'b1;
        end
        default: begin
          // HOLD and the reserved code leave everything as it is.
          w_next_data   = r_data;
          w_next_serial = r_serial_out;
        end
      endcase
    end
  end

  // Register the data path and the frame counter. A load or clear always
  // wins over frame completion, so it never emits a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data       <= RESET_VAL;
      r_serial_out <= 1'b0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_data       <= w_next_data;
      r_serial_out <= w_next_serial;
      if (w_count_clr) begin
        r_count      <= '0;
        r_frame_done <= 1'b0;
      end else if (w_shift_op) begin
        if (r_count == LAST_COUNT) begin
          r_count      <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_count      <= r_count + CW'(1);
          r_frame_done <= 1'b0;
        end
      end else begin
        r_frame_done <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_serial_out = r_serial_out;
  assign o_count      = r_count;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed bench for shift_reg_univ at WIDTH=8.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_ROL   = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_LOAD  = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;
  localparam logic [2:0] M_RSVD  = 3'b111;

  logic          clk;
  logic          reset;
  logic          i_en;
  logic [2:0]    i_mode;
  logic          i_serial_in;
  logic [W-1:0]  i_data;
  logic [W-1:0]  o_data;
  logic          o_serial_out;
  logic [CW-1:0] o_count;
  logic          o_frame_done;

  int checks;
  int failures;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_en         (i_en),
    .i_mode       (i_mode),
    .i_serial_in  (i_serial_in),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_serial_out (o_serial_out),
    .o_count      (o_count),
    .o_frame_done (o_frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] d, input logic so,
                           input logic [CW-1:0] cnt, input logic fd);
    check_eq({tag, ".data"},  64'(o_data),       64'(d));
    check_eq({tag, ".sout"},  64'(o_serial_out), 64'(so));
    check_eq({tag, ".count"}, 64'(o_count),      64'(cnt));
    check_eq({tag, ".frame"}, 64'(o_frame_done), 64'(fd));
  endtask

  // driver: present one operation, let one edge execute it, settle 1ns past it
  task automatic do_op(input logic en, input logic [2:0] mode, input logic sin,
                       input logic [W-1:0] din);
    i_en        = en;
    i_mode      = mode;
    i_serial_in = sin;
    i_data      = din;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rol8(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1]};
  endfunction

  function automatic logic [W-1:0] ror8(input logic [W-1:0] v);
    return {v[0], v[W-1:1]};
  endfunction

  logic [7:0]   ser_exp;
  logic [7:0]   des_bits;
  logic [W-1:0] rot_model;

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    i_en        = 1'b0;
    i_mode      = M_HOLD;
    i_serial_in = 1'b0;
    i_data      = '0;
    ser_exp     = 8'hA5;
    des_bits    = 8'b1100_1010;  // sent in this order, MSB of the constant first

    // Reset held: random inputs must not disturb the reset state.
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
      check_all("reset_hold", 8'h00, 1'b0, '0, 1'b0);
    end
    reset = 1'b0;

    // First operation after release.
    do_op(1'b1, M_LOAD, 1'b0, 8'hA5);
    check_all("load_a5", 8'hA5, 1'b0, '0, 1'b0);

    // Serialise A5 MSB first through SHL.
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, M_SHL, 1'b0, 8'h00);
      check_eq("ser.sout",  64'(o_serial_out), 64'(ser_exp[7-i]));
      check_eq("ser.count", 64'(o_count),      64'((i + 1) % 8));
      check_eq("ser.frame", 64'(o_frame_done), 64'(i == 7));
    end
    check_eq("ser.data_end", 64'(o_data), 64'h00);
    // Disabled edge drops the pulse and holds everything else.
    do_op(1'b0, M_SHL, 1'b1, 8'h00);
    check_all("ser_after_en0", 8'h00, 1'b1, '0, 1'b0);

    // Deserialise through SHR from CLEAR.
    do_op(1'b1, M_CLEAR, 1'b0, 8'h00);
    check_all("clear", 8'h00, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, M_SHR, des_bits[7-i], 8'h00);
      check_eq("des.frame", 64'(o_frame_done), 64'(i == 7));
    end
    check_eq("des.data",  64'(o_data),  64'h53);
    check_eq("des.count", 64'(o_count), 64'h0);

    // Rotate: 3 left, then 5 right; mixed directions share one frame.
    do_op(1'b1, M_LOAD, 1'b0, 8'h81);
    rot_model = 8'h81;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, M_ROL, 1'b0, 8'h00);
      rot_model = rol8(rot_model);
    end
    check_eq("rol3.data",  64'(o_data),  64'h0C);
    check_eq("rol3.count", 64'(o_count), 64'h3);
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, M_ROR, 1'b1, 8'h00);
      rot_model = ror8(rot_model);
      check_eq("ror.frame", 64'(o_frame_done), 64'(i == 4));
    end
    check_eq("ror5.data",  64'(o_data),  64'(rot_model));
    check_eq("ror5.const", 64'(o_data),  64'h60);
    check_eq("ror5.count", 64'(o_count), 64'h0);

    // Enable low and HOLD/reserved with enable high change nothing.
    do_op(1'b1, M_LOAD, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, M_SHL, 1'b1, 8'hFF);
      check_all("en0_hold", 8'h3C, 1'b0, '0, 1'b0);
    end
    do_op(1'b1, M_HOLD, 1'b1, 8'hFF);
    check_all("mode_hold", 8'h3C, 1'b0, '0, 1'b0);
    do_op(1'b1, M_RSVD, 1'b1, 8'hFF);
    check_all("mode_rsvd", 8'h3C, 1'b0, '0, 1'b0);

    // Abort: LOAD on the would-be frame-completing edge.
    do_op(1'b1, M_LOAD, 1'b0, 8'hC3);
    for (int i = 0; i < 7; i++) do_op(1'b1, M_SHL, 1'b1, 8'h00);
    check_all("abort_pre", 8'hFF, 1'b1, CW'(7), 1'b0);
    do_op(1'b1, M_LOAD, 1'b0, 8'hFF);
    check_all("abort_load", 8'hFF, 1'b0, '0, 1'b0);
    do_op(1'b1, M_HOLD, 1'b0, 8'h00);
    check_eq("abort_nopulse", 64'(o_frame_done), 64'h0);

    // Asynchronous reset between edges discards a partial frame.
    for (int i = 0; i < 3; i++) do_op(1'b1, M_SHL, 1'b0, 8'h00);
    check_all("mid_pre", 8'hF8, 1'b1, CW'(3), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b0;
    do_op(1'b1, M_SHL, 1'b1, 8'h00);
    check_all("post_rst", 8'h01, 1'b0, CW'(1), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
